if_fetch_unit: RTL and testbench

- Instruction-fetch stage that drives the instruction and PC+4 inputs of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Absorbs memory latency, hazard-unit holds and branch/jump redirects.
- Reports when no valid instruction is available; top level ORs that into the IF/ID flush to insert a bubble.

---
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// presents one instruction (or a bubble) per cycle to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hold,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ReadInst,
  output logic [31:0] o_IF_PC_Plus_4,
  output logic        o_inst_valid,
  output logic [31:0] o_PC
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_BUFFERED = 2'd1,
    S_DISCARD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pending_pc;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc4;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pending_pc_nxt;
  logic [31:0] w_buf_inst_nxt;
  logic [31:0] w_buf_pc4_nxt;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_plus_4;

  assign w_redir_pc  = {i_redirect_pc[31:2], 2'b00};
  assign w_pc_plus_4 = r_pc + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_pending_pc <= 32'd0;
      r_buf_inst   <= 32'd0;
      r_buf_pc4    <= 32'd0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_pc_nxt;
      r_buf_inst   <= w_buf_inst_nxt;
      r_buf_pc4    <= w_buf_pc4_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pending_pc_nxt = r_pending_pc;
    w_buf_inst_nxt   = r_buf_inst;
    w_buf_pc4_nxt    = r_buf_pc4;
    case (r_state)
      S_FETCH: begin
        if (i_redirect) begin
          // An outstanding request cannot be withdrawn, so a redirect without
          // ready parks the target and drops the in-flight word later.
          if (i_imem_ready) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_pending_pc_nxt = w_redir_pc;
            w_state_nxt      = S_DISCARD;
          end
        end else if (i_imem_ready) begin
          w_pc_nxt = w_pc_plus_4;
          if (i_hold) begin
            w_buf_inst_nxt = i_imem_rdata;
            w_buf_pc4_nxt  = w_pc_plus_4;
            w_state_nxt    = S_BUFFERED;
          end
        end
      end
      S_BUFFERED: begin
        if (i_redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_FETCH;
        end else if (!i_hold) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (i_redirect) begin
          w_pending_pc_nxt = w_redir_pc;
        end
        if (i_imem_ready) begin
          w_pc_nxt    = i_redirect ? w_redir_pc : r_pending_pc;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_comb begin
    o_imem_req     = 1'b0;
    o_imem_addr    = r_pc;
    o_inst_valid   = 1'b0;
    o_ReadInst     = 32'd0;
    o_IF_PC_Plus_4 = 32'd0;
    o_PC           = r_pc;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          if (!i_redirect && i_imem_ready) begin
            o_inst_valid   = 1'b1;
            o_ReadInst     = i_imem_rdata;
            o_IF_PC_Plus_4 = w_pc_plus_4;
          end
        end
        S_BUFFERED: begin
          if (!i_redirect) begin
            o_inst_valid   = 1'b1;
            o_ReadInst     = r_buf_inst;
            o_IF_PC_Plus_4 = r_buf_pc4;
          end
        end
        S_DISCARD: begin
          o_imem_req = 1'b1;
        end
        default: begin
          o_imem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, checked
// against a reference model of the fetch rules and a word-per-address memory.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_hold = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'd0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready = 1'b0;
  logic [31:0] i_imem_rdata = 32'd0;
  logic [31:0] o_ReadInst;
  logic [31:0] o_IF_PC_Plus_4;
  logic        o_inst_valid;
  logic [31:0] o_PC;

  int errors = 0;
  int checks = 0;

  // Reference model: fetch pointer, parked redirect target, held instruction.
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] m_held_inst;
  logic [31:0] m_held_pc4;
  bit          m_holding;
  bit          m_dropping;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .i_hold(i_hold), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ready(i_imem_ready), .i_imem_rdata(i_imem_rdata), .o_ReadInst(o_ReadInst),
    .o_IF_PC_Plus_4(o_IF_PC_Plus_4), .o_inst_valid(o_inst_valid), .o_PC(o_PC)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_pend = 32'd0; m_held_inst = 32'd0; m_held_pc4 = 32'd0;
    m_holding = 0; m_dropping = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_inst", o_ReadInst, 32'd0);
    chk("rst_pc4", o_IF_PC_Plus_4, 32'd0);
    chk("rst_pc", o_PC, RESET_PC);
  endtask

  // One clock cycle: drive, compare against the model, clock, advance model.
  task automatic cyc(input bit hold, input bit redir, input logic [31:0] rpc, input bit rdy);
    logic [31:0] rd, tgt, e_inst, e_pc4;
    bit e_req, e_valid;
    rd = rdy ? mem_word(m_pc) : $urandom;
    tgt = {rpc[31:2], 2'b00};
    i_hold = hold; i_redirect = redir; i_redirect_pc = rpc;
    i_imem_ready = rdy; i_imem_rdata = rd;
    #2;
    if (m_holding) begin
      e_req = 0; e_valid = !redir; e_inst = m_held_inst; e_pc4 = m_held_pc4;
    end else begin
      e_req = 1; e_valid = !m_dropping && !redir && rdy; e_inst = rd; e_pc4 = m_pc + 32'd4;
    end
    if (!e_valid) begin
      e_inst = 32'd0; e_pc4 = 32'd0;
    end
    chk("req", {31'd0, o_imem_req}, {31'd0, e_req});
    chk("valid", {31'd0, o_inst_valid}, {31'd0, e_valid});
    chk("inst", o_ReadInst, e_inst);
    chk("pc4", o_IF_PC_Plus_4, e_pc4);
    chk("pc", o_PC, m_pc);
    if (e_req) chk("addr", o_imem_addr, m_pc);
    if (o_inst_valid === 1'b1) chk("inst_matches_pc", o_ReadInst, mem_word(o_IF_PC_Plus_4 - 32'd4));
    @(posedge clk);
    if (m_holding) begin
      if (redir) begin m_pc = tgt; m_holding = 0; end
      else if (!hold) m_holding = 0;
    end else if (m_dropping) begin
      if (redir) m_pend = tgt;
      if (rdy) begin m_pc = m_pend; m_dropping = 0; end
    end else if (redir) begin
      if (rdy) m_pc = tgt;
      else begin m_pend = tgt; m_dropping = 1; end
    end else if (rdy) begin
      if (hold) begin
        m_held_inst = rd; m_held_pc4 = m_pc + 32'd4; m_holding = 1;
      end
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    i_hold = 0; i_redirect = 0; i_imem_ready = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    chk_reset_outputs();
    release_reset();

    repeat (4) cyc(0, 0, 32'd0, 1);
    chk("seq_addr_16", o_imem_addr, 32'd16);

    cyc(0, 1, 32'd8, 1);
    repeat (3) cyc(0, 0, 32'd0, 0);
    chk("stall_addr_held", o_imem_addr, 32'd8);
    cyc(0, 0, 32'd0, 1);

    cyc(0, 1, 32'd4, 1);
    cyc(1, 0, 32'd0, 1);
    cyc(1, 0, 32'd0, 1);
    chk("buffered_pc4", o_IF_PC_Plus_4, 32'd8);
    cyc(0, 0, 32'd0, 1);
    chk("after_hold_addr", o_imem_addr, 32'd8);
    cyc(0, 0, 32'd0, 1);
    cyc(0, 0, 32'd0, 1);

    cyc(0, 1, 32'h100, 0);
    cyc(0, 1, 32'h200, 0);
    chk("discard_addr_old", o_imem_addr, 32'd16);
    cyc(0, 0, 32'd0, 1);
    chk("latest_redirect", o_imem_addr, 32'h200);
    cyc(0, 0, 32'd0, 1);

    cyc(1, 0, 32'd0, 1);
    cyc(1, 1, 32'h43, 0);
    chk("redir_align", o_imem_addr, 32'h40);
    cyc(0, 0, 32'd0, 1);

    cyc(0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 32'd0, 1);
    chk("wrap_addr", o_imem_addr, 32'd0);

    cyc(0, 1, 32'h300, 0);
    cyc(0, 1, 32'h500, 1);
    chk("discard_redir_ready", o_imem_addr, 32'h500);

    cyc(0, 1, 32'h700, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    release_reset();
    chk("restart_addr", o_imem_addr, RESET_PC);

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom,
          $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
